alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 125 ++++++++++++
 tb/tb_alu_exec_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Single-cycle ALU feeding a small in-order result FIFO that drains onto the CDB under arbiter grant.
// Optional perf counters (perf_issued, perf_stall) are built when ALU_EXEC_UNIT_PERF_EN is defined.
module alu_exec_unit #(
    parameter int PD_W  = 6,
    parameter int ROB_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic [31:0]      issue_a,
    input  logic [31:0]      issue_b,
    input  logic [PD_W-1:0]  issue_pd,
    input  logic [ROB_W-1:0] issue_rob,
    output logic             cdb_req,
    input  logic             cdb_gnt,
    output logic             cdb_valid,
    output logic [PD_W-1:0]  cdb_pd,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [31:0]      cdb_data
`ifdef ALU_EXEC_UNIT_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [PD_W-1:0]  pd_mem   [DEPTH];
    logic [ROB_W-1:0] rob_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      alu_res;
    logic [31:0]      wr_data;
    logic [4:0]       shamt;
    logic             push, pop;

    assign issue_ready = (count_q < CW'(DEPTH));
    assign cdb_req     = (count_q != '0);
    assign cdb_valid   = cdb_req & cdb_gnt & ~flush;
    assign push        = issue_valid & issue_ready & ~flush;
    assign pop         = cdb_valid;

    assign cdb_pd   = cdb_req ? pd_mem[rd_ptr_q]   : '0;
    assign cdb_rob  = cdb_req ? rob_mem[rd_ptr_q]  : '0;
    assign cdb_data = cdb_req ? data_mem[rd_ptr_q] : '0;

    assign shamt = issue_b[4:0];

    always_comb begin
        alu_res = '0;
        case (issue_op)
            4'd0:    alu_res = issue_a + issue_b;
            4'd1:    alu_res = issue_a - issue_b;
            4'd2:    alu_res = issue_a << shamt;
            4'd3:    alu_res = {31'b0, $signed(issue_a) < $signed(issue_b)};
            4'd4:    alu_res = {31'b0, issue_a < issue_b};
            4'd5:    alu_res = issue_a ^ issue_b;
            4'd6:    alu_res = issue_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(issue_a) >>> shamt);
            4'd8:    alu_res = issue_a | issue_b;
            4'd9:    alu_res = issue_a & issue_b;
            4'd10:   alu_res = issue_b;
            default: alu_res = '0;
        endcase
    end

    // p0 is the hardwired-zero register, so its broadcast value must be 0
    assign wr_data = (issue_pd == '0) ? 32'h0 : alu_res;

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked by cdb_req while empty
    always_ff @(posedge clk) begin
        if (push) begin
            pd_mem[wr_ptr_q]   <= issue_pd;
            rob_mem[wr_ptr_q]  <= issue_rob;
            data_mem[wr_ptr_q] <= wr_data;
        end
    end

`ifdef ALU_EXEC_UNIT_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (push)                        perf_issued_q <= perf_issued_q + 32'd1;
            if (issue_valid && !issue_ready) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized + directed bench for alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;
    localparam int PD_W  = 6;
    localparam int ROB_W = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic [PD_W-1:0]  pd;
        logic [ROB_W-1:0] rob;
        logic [31:0]      d;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, issue_valid, issue_ready;
    logic [3:0]       issue_op;
    logic [31:0]      issue_a, issue_b;
    logic [PD_W-1:0]  issue_pd;
    logic [ROB_W-1:0] issue_rob;
    logic             cdb_req, cdb_gnt, cdb_valid;
    logic [PD_W-1:0]  cdb_pd;
    logic [ROB_W-1:0] cdb_rob;
    logic [31:0]      cdb_data;
`ifdef ALU_EXEC_UNIT_PERF_EN
    logic [31:0]      perf_issued, perf_stall;
`endif

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_exec_unit #(.PD_W(PD_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
        .issue_pd(issue_pd), .issue_rob(issue_rob),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_valid(cdb_valid),
        .cdb_pd(cdb_pd), .cdb_rob(cdb_rob), .cdb_data(cdb_data)
`ifdef ALU_EXEC_UNIT_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU written from the opcode table, not from the RTL
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b[4:0];
        case (op)
            0:  r = a + b;
            1:  r = a + ~b + 32'd1;
            2:  r = a * (32'd1 << sh);
            3:  r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            4:  r = {31'b0, a < b};
            5:  r = (a | b) & ~(a & b);
            6:  r = a / (32'd1 << sh);
            7:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            8:  r = a | b;
            9:  r = a & b;
            10: r = b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Apply inputs at negedge, compare outputs, then advance the model at posedge
    task automatic drive(input logic iv, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [PD_W-1:0] pd, input logic [ROB_W-1:0] rob,
                         input logic gnt, input logic fl);
        logic e_rdy, e_req, e_vld;
        ent_t e;
        issue_valid = iv; issue_op = op; issue_a = a; issue_b = b;
        issue_pd = pd; issue_rob = rob; cdb_gnt = gnt; flush = fl;
        #1;
        e_rdy = (q.size() < DEPTH);
        e_req = (q.size() != 0);
        e_vld = e_req && gnt && !fl;
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, e_rdy});
        chk("cdb_req",     {31'b0, cdb_req},     {31'b0, e_req});
        chk("cdb_valid",   {31'b0, cdb_valid},   {31'b0, e_vld});
        chk("cdb_pd",      32'(cdb_pd),          e_req ? 32'(q[0].pd)  : 32'h0);
        chk("cdb_rob",     32'(cdb_rob),         e_req ? 32'(q[0].rob) : 32'h0);
        chk("cdb_data",    cdb_data,             e_req ? q[0].d        : 32'h0);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (e_vld) void'(q.pop_front());
            if (iv && e_rdy) begin
                e.pd = pd; e.rob = rob; e.d = (pd == 0) ? 32'h0 : ref_alu(op, a, b);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic gnt);
        drive(1'b0, 4'd0, 32'h0, 32'h0, '0, '0, gnt, 1'b0);
    endtask

    task automatic expect_head(input string tag, input logic [PD_W-1:0] pd, input logic [ROB_W-1:0] rob,
                               input logic [31:0] d);
        chk({tag, "_req"},  {31'b0, cdb_req}, 32'h1);
        chk({tag, "_pd"},   32'(cdb_pd),      32'(pd));
        chk({tag, "_rob"},  32'(cdb_rob),     32'(rob));
        chk({tag, "_data"}, cdb_data,         d);
    endtask

    task automatic do_reset();
        issue_valid = 1'b0; cdb_gnt = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req",   {31'b0, cdb_req},     32'h0);
        chk("rst_vld",   {31'b0, cdb_valid},   32'h0);
        chk("rst_rdy",   {31'b0, issue_ready}, 32'h1);
        chk("rst_data",  cdb_data,             32'h0);
        chk("rst_pd",    32'(cdb_pd),          32'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b1;
        issue_valid = 1'b0; issue_op = '0; issue_a = '0; issue_b = '0;
        issue_pd = '0; issue_rob = '0; cdb_gnt = 1'b0; flush = 1'b0;
        @(negedge clk);
        do_reset();

        // Overflowing ADD visible at the head one cycle after issue
        drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1, 6'd5, 5'd3, 1'b1, 1'b0);
        expect_head("add", 6'd5, 5'd3, 32'h8000_0000);
        idle(1'b1);

        // SRA then SLTU, back-to-back with grant held
        drive(1'b1, 4'd7, 32'h8000_0000, 32'h24, 6'd7, 5'd1, 1'b1, 1'b0);
        expect_head("sra", 6'd7, 5'd1, 32'hF800_0000);
        drive(1'b1, 4'd4, 32'h1, 32'hFFFF_FFFF, 6'd8, 5'd2, 1'b1, 1'b0);
        expect_head("sltu", 6'd8, 5'd2, 32'h1);
        idle(1'b1);

        // Fill with grant low; third issue must be ignored
        drive(1'b1, 4'd1, 32'd10, 32'd3, 6'd9, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 32'hF0F0, 32'hFF00, 6'd10, 5'd5, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 32'h1, 32'h2, 6'd11, 5'd6, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        expect_head("hold", 6'd9, 5'd4, 32'd7);
        // Full with grant and issue together: pop only, then issue lands
        drive(1'b1, 4'd9, 32'hFF, 32'h0F, 6'd12, 5'd7, 1'b1, 1'b0);
        drive(1'b1, 4'd9, 32'hFF, 32'h0F, 6'd12, 5'd7, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with grant high and two entries queued
        drive(1'b1, 4'd2, 32'h1, 32'h1F, 6'd1, 5'd1, 1'b0, 1'b0);
        drive(1'b1, 4'd6, 32'h8000_0000, 32'h1F, 6'd2, 5'd2, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 32'h1, 32'h1, 6'd3, 5'd3, 1'b1, 1'b1);
        idle(1'b1);

        // pd=0 forces zero data, then reset while entries are queued
        drive(1'b1, 4'd8, 32'hFF, 32'h1, 6'd0, 5'd9, 1'b0, 1'b0);
        expect_head("p0", 6'd0, 5'd9, 32'h0);
        drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, 6'd4, 5'd10, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, 4'd10, 32'h0, 32'hCAFE, 6'd6, 5'd11, 1'b1, 1'b0);
        expect_head("post_rst", 6'd6, 5'd11, 32'hCAFE);
        idle(1'b1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rnd_word(), rnd_word(),
                  ($urandom_range(0, 7) == 0) ? '0 : PD_W'($urandom),
                  ROB_W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
